// File: rtl/mips_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, select codes,
// FSM state encodings and the bundled control-word type.
package mips_mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [1:0] ALU_OP_ADD      = 2'd0;
    localparam logic [1:0] ALU_OP_SUB      = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT    = 2'd2;
    localparam logic [1:0] ALU_OP_SPECIAL2 = 2'd3;

    localparam logic [1:0] SRC_B_REG     = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC    = 4'd2,
        S_ALU_WB  = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WB  = 4'd6,
        S_MEM_WR  = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SPECIAL2) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// Combinational control-word decode: maps the current FSM state (plus the few live
// inputs that gate strobes) onto every datapath enable and mux select.
module mips_mc_ctrl_decode
    import mips_mc_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    logic pc_write;
    logic pc_write_cond;

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        ctrl_o        = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRC_B_FOUR;
                ctrl_o.alu_op    = ALU_OP_ADD;
                ctrl_o.pc_source = PC_SRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                pc_write         = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b  = SRC_B_IMM_SH2;
                ctrl_o.alu_op     = ALU_OP_ADD;
                ctrl_o.illegal_op = !is_legal_op(opcode_i);
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_REG;
                ctrl_o.alu_op    = (opcode_i == OP_SPECIAL2) ? ALU_OP_SPECIAL2 : ALU_OP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_ADR, S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRC_B_REG;
                ctrl_o.alu_op     = ALU_OP_SUB;
                ctrl_o.pc_source  = PC_SRC_ALUOUT;
                ctrl_o.instr_done = 1'b1;
                pc_write_cond     = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_source  = PC_SRC_JUMP;
                ctrl_o.instr_done = 1'b1;
                pc_write          = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ;
        endcase
        ctrl_o.pc_en = pc_write | (pc_write_cond & zero_i);
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic and the
// retired-instruction counter; control outputs come from mips_mc_ctrl_decode.
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    ctrl_t            ctrl, ctrl_gated;

    mips_mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .zero_i      (zero),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE, OP_SPECIAL2: state_d = S_EXEC;
                    OP_LW, OP_SW:          state_d = S_MEM_ADR;
                    OP_BEQ:                state_d = S_BRANCH;
                    OP_J:                  state_d = S_JUMP;
                    OP_ADDI:               state_d = S_ADDI_EX;
                    default:               state_d = S_FETCH;
                endcase
            end
            S_EXEC:    state_d = S_ALU_WB;
            S_MEM_ADR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:  if (mem_ready) state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            default:   state_d = S_FETCH;
        endcase
    end

    assign count_d = count_q + CNT_W'(ctrl.instr_done);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Reset must silence the datapath immediately, not just at the next edge.
    assign ctrl_gated = rst ? '0 : ctrl;

    assign pc_en       = ctrl_gated.pc_en;
    assign i_or_d      = ctrl_gated.i_or_d;
    assign mem_read    = ctrl_gated.mem_read;
    assign mem_write   = ctrl_gated.mem_write;
    assign ir_write    = ctrl_gated.ir_write;
    assign reg_dst     = ctrl_gated.reg_dst;
    assign mem_to_reg  = ctrl_gated.mem_to_reg;
    assign reg_write   = ctrl_gated.reg_write;
    assign alu_src_a   = ctrl_gated.alu_src_a;
    assign alu_src_b   = ctrl_gated.alu_src_b;
    assign alu_op      = ctrl_gated.alu_op;
    assign pc_source   = ctrl_gated.pc_source;
    assign illegal_op  = ctrl_gated.illegal_op;
    assign instr_done  = ctrl_gated.instr_done;
    assign instr_count = count_q;

endmodule
